// File: rtl/emib_cfg_loader_if.sv
// EMIB RAM read port: registered address/enable out, read data back RD_LAT
// cycles later. The loader is the master and the RAM is the slave.
interface emib_cfg_loader_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] o_emib_addr;
    logic              o_rd_ram_en;
    logic [DATA_W-1:0] i_emib_data;

    modport master (output o_emib_addr, output o_rd_ram_en, input  i_emib_data);
    modport slave  (input  o_emib_addr, input  o_rd_ram_en, output i_emib_data);
endinterface

// File: rtl/emib_cfg_loader.sv
// Table-driven EMIB configuration loader. On a start trigger it reads every
// ADDR_LIST entry through the pipelined EMIB read port into a shadow bank,
// then copies the whole bank to o_cfg_words in one cycle so downstream never
// sees a partially updated configuration.
// Build option: define EMIB_CFG_CHECKSUM_EN to read one extra word at
// CSUM_ADDR and commit only if it equals the modulo-2^DATA_W sum of the bank.
module emib_cfg_loader #(
    parameter int unsigned                 ADDR_W     = 16,
    parameter int unsigned                 DATA_W     = 16,
    parameter int unsigned                 NUM_WORDS  = 24,
    parameter int unsigned                 RD_LAT     = 3,
    parameter logic [NUM_WORDS*ADDR_W-1:0] ADDR_LIST  = '0,
    parameter logic [NUM_WORDS*DATA_W-1:0] RESET_VALS = '0,
    parameter logic [ADDR_W-1:0]           CSUM_ADDR  = 16'h0070
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_read_flash_done,
    input  logic                          i_config_flag,
    input  logic                          i_reload,
    emib_cfg_loader_if.master             emib,
    output logic [NUM_WORDS*DATA_W-1:0]   o_cfg_words,
    output logic                          o_busy,
    output logic                          o_commen_data_rd_done,
    output logic                          o_commit,
    output logic [7:0]                    o_load_cnt,
    output logic                          o_csum_err
);

`ifdef EMIB_CFG_CHECKSUM_EN
    localparam int unsigned NUM_RD = NUM_WORDS + 1;
`else
    localparam int unsigned NUM_RD = NUM_WORDS;
`endif
    // Wide enough to also name the checksum read (index NUM_WORDS).
    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          rd_idx_q;
    logic [IDX_W-1:0]          issue_idx;
    logic [ADDR_W-1:0]         issue_addr;
    logic                      issue;
    logic                      commit_go;
    logic                      drain_done;
    logic                      csum_ok;
    logic                      start_lvl, start_q, trig;
    logic                      pipe_vld [RD_LAT];
    logic [IDX_W-1:0]          pipe_idx [RD_LAT];
    logic [NUM_WORDS*DATA_W-1:0] shadow;

`ifdef EMIB_CFG_CHECKSUM_EN
    logic [DATA_W-1:0]         sum_q, csum_q;
`endif

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] k);
        if (k < IDX_W'(NUM_WORDS))
            return ADDR_LIST[k * ADDR_W +: ADDR_W];
        return CSUM_ADDR;
    endfunction

    assign start_lvl = i_read_flash_done & i_config_flag;
    assign trig      = (start_lvl & ~start_q) | (i_reload & i_config_flag);
    assign o_busy    = (state_q != IDLE);
    assign o_commit  = commit_go;

    // Checksum verdict for the COMMIT cycle; always passes when the check is not built.
`ifdef EMIB_CFG_CHECKSUM_EN
    always_comb csum_ok = (sum_q == csum_q);
`else
    always_comb csum_ok = 1'b1;
    assign o_csum_err = 1'b0;
`endif

    // Drain ends when nothing older than the read being captured now is left in flight.
    always_comb begin
        drain_done = ~emib.o_rd_ram_en;
        for (int unsigned s = 0; s + 1 < RD_LAT; s++) begin
            if (pipe_vld[s])
                drain_done = 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and read issue; word 0 is issued on the trigger edge itself
    // so the first address appears the cycle after the trigger.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        issue      = 1'b0;
        issue_idx  = '0;
        issue_addr = '0;
        commit_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    issue      = 1'b1;
                    issue_addr = addr_of('0);
                    idx_d      = IDX_W'(1);
                    state_d    = (NUM_RD == 1) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                issue_idx  = idx_q;
                issue_addr = addr_of(idx_q);
                idx_d      = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_RD - 1)) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done)
                    state_d = COMMIT;
            end
            COMMIT: begin
                commit_go = csum_ok;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read port registers, capture pipeline, shadow bank and committed outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            start_q               <= 1'b0;
            emib.o_rd_ram_en      <= 1'b0;
            emib.o_emib_addr      <= '0;
            rd_idx_q              <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_idx[s] <= '0;
            end
            shadow                <= RESET_VALS;
            o_cfg_words           <= RESET_VALS;
            o_load_cnt            <= '0;
            o_commen_data_rd_done <= 1'b0;
`ifdef EMIB_CFG_CHECKSUM_EN
            sum_q                 <= '0;
            csum_q                <= '0;
            o_csum_err            <= 1'b0;
`endif
        end else begin
            start_q          <= start_lvl;
            emib.o_rd_ram_en <= issue;
            emib.o_emib_addr <= issue_addr;
            rd_idx_q         <= issue_idx;
            pipe_vld[0]      <= emib.o_rd_ram_en;
            pipe_idx[0]      <= rd_idx_q;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_idx[s] <= pipe_idx[s-1];
            end
            if (pipe_vld[RD_LAT-1]) begin
`ifdef EMIB_CFG_CHECKSUM_EN
                if (pipe_idx[RD_LAT-1] == IDX_W'(NUM_WORDS)) begin
                    csum_q <= emib.i_emib_data;
                end else begin
                    shadow[pipe_idx[RD_LAT-1] * DATA_W +: DATA_W] <= emib.i_emib_data;
                    sum_q <= sum_q + emib.i_emib_data;
                end
`else
                shadow[pipe_idx[RD_LAT-1] * DATA_W +: DATA_W] <= emib.i_emib_data;
`endif
            end
            if (state_q == COMMIT) begin
                if (commit_go) begin
                    o_cfg_words           <= shadow;
                    o_load_cnt            <= o_load_cnt + 8'd1;
                    o_commen_data_rd_done <= 1'b1;
                end
`ifdef EMIB_CFG_CHECKSUM_EN
                o_csum_err <= ~csum_ok;
                sum_q      <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_emib_cfg_loader.sv
// Self-checking bench for emib_cfg_loader: one 4-word/RD_LAT=3 loader plus two
// single-word loaders (RD_LAT=1 and RD_LAT=5) sharing the control inputs, each
// with its own RAM model. Expected banks, commit cycles and counters come from
// a per-load model built from the address tables and the RAM contents.
module tb_emib_cfg_loader;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam logic [63:0] LIST_M = {16'h0026, 16'h002E, 16'h002D, 16'h002C};
    localparam logic [63:0] RST_M  = 64'h4444_3333_2222_1111;
    localparam logic [15:0] RST_A  = 16'hBEEF;
    localparam logic [15:0] CSUM_A = 16'h0070;
`ifdef EMIB_CFG_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NW  [3] = '{4, 1, 1};
    localparam int LAT [3] = '{3, 1, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flash_done, cfg_flag, reload;
    logic [63:0] cfg_m;
    logic [15:0] cfg_a, cfg_b;
    logic [2:0]  busy, done, commit, err;
    logic [7:0]  cnt_m, cnt_a, cnt_b;

    emib_cfg_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_m ();
    emib_cfg_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    emib_cfg_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    emib_cfg_loader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(4), .RD_LAT(3),
        .ADDR_LIST(LIST_M), .RESET_VALS(RST_M), .CSUM_ADDR(CSUM_A)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_read_flash_done(flash_done), .i_config_flag(cfg_flag),
        .i_reload(reload), .emib(bus_m), .o_cfg_words(cfg_m), .o_busy(busy[0]),
        .o_commen_data_rd_done(done[0]), .o_commit(commit[0]), .o_load_cnt(cnt_m), .o_csum_err(err[0]));

    emib_cfg_loader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(1), .RD_LAT(1),
        .ADDR_LIST(16'h0005), .RESET_VALS(RST_A), .CSUM_ADDR(CSUM_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_read_flash_done(flash_done), .i_config_flag(cfg_flag),
        .i_reload(reload), .emib(bus_a), .o_cfg_words(cfg_a), .o_busy(busy[1]),
        .o_commen_data_rd_done(done[1]), .o_commit(commit[1]), .o_load_cnt(cnt_a), .o_csum_err(err[1]));

    emib_cfg_loader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(1), .RD_LAT(5),
        .ADDR_LIST(16'h0005), .CSUM_ADDR(CSUM_A)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_read_flash_done(flash_done), .i_config_flag(cfg_flag),
        .i_reload(reload), .emib(bus_b), .o_cfg_words(cfg_b), .o_busy(busy[2]),
        .o_commen_data_rd_done(done[2]), .o_commit(commit[2]), .o_load_cnt(cnt_b), .o_csum_err(err[2]));

    // RAM models: data for a read appears exactly LAT cycles after its enable; junk otherwise.
    logic [15:0] mem [256];
    logic [15:0] pm [3];
    logic [15:0] pa [1];
    logic [15:0] pb [5];
    always @(posedge clk) begin
        pm[0] <= bus_m.o_rd_ram_en ? mem[bus_m.o_emib_addr[7:0]] : 16'($urandom);
        for (int i = 1; i < 3; i++) pm[i] <= pm[i-1];
        pa[0] <= bus_a.o_rd_ram_en ? mem[bus_a.o_emib_addr[7:0]] : 16'($urandom);
        pb[0] <= bus_b.o_rd_ram_en ? mem[bus_b.o_emib_addr[7:0]] : 16'($urandom);
        for (int i = 1; i < 5; i++) pb[i] <= pb[i-1];
    end
    assign bus_m.i_emib_data = pm[2];
    assign bus_a.i_emib_data = pa[0];
    assign bus_b.i_emib_data = pb[4];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [15:0] tab [4] = '{16'h002C, 16'h002D, 16'h002E, 16'h0026};
    logic [63:0] exp_bank [3];
    logic [7:0]  exp_cnt [3];
    logic        exp_done [3];
    logic        exp_err [3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_cfg(input int d);
        case (d)
            0:       return cfg_m;
            1:       return {48'h0, cfg_a};
            default: return {48'h0, cfg_b};
        endcase
    endfunction

    function automatic logic [7:0] obs_cnt(input int d);
        case (d)
            0:       return cnt_m;
            1:       return cnt_a;
            default: return cnt_b;
        endcase
    endfunction

    function automatic logic [15:0] exp_addr(input int d, input int k);
        if (k == NW[d]) return CSUM_A;
        if (d == 0)     return tab[k];
        return 16'h0005;
    endfunction

    task automatic model_reset();
        exp_bank[0] = RST_M;
        exp_bank[1] = {48'h0, RST_A};
        exp_bank[2] = 64'h0;
        for (int d = 0; d < 3; d++) begin
            exp_cnt[d] = 8'd0; exp_done[d] = 1'b0; exp_err[d] = 1'b0;
        end
    endtask

    task automatic randomize_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    endtask

    task automatic fix_csum();
        mem[CSUM_A[7:0]] = mem[8'h2C] + mem[8'h2D] + mem[8'h2E] + mem[8'h26];
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_cfg%0d", tag, d), obs_cfg(d), exp_bank[d]);
            chk($sformatf("%s_busy%0d", tag, d), 64'(busy[d]), 64'd0);
            chk($sformatf("%s_commit%0d", tag, d), 64'(commit[d]), 64'd0);
            chk($sformatf("%s_cnt%0d", tag, d), 64'(obs_cnt(d)), 64'(exp_cnt[d]));
            chk($sformatf("%s_done%0d", tag, d), 64'(done[d]), 64'(exp_done[d]));
            chk($sformatf("%s_err%0d", tag, d), 64'(err[d]), 64'(exp_err[d]));
        end
        chk({tag, "_en"}, 64'(bus_m.o_rd_ram_en), 64'd0);
        chk({tag, "_addr"}, 64'(bus_m.o_emib_addr), 64'd0);
    endtask

    // how: 0 = reload pulse, 1 = raise flash_done & config_flag.
    // poke: cycle after the trigger in which a second reload is pulsed (0 = none).
    // drop: deassert config_flag two cycles into the load.
    task automatic load(input int how, input int poke, input bit drop);
        logic [63:0] newb [3];
        bit          ok [3];
        int          lend [3];
        logic [15:0] w, s;
        for (int d = 0; d < 3; d++) begin
            newb[d] = 64'h0;
            s = 16'h0;
            for (int k = 0; k < NW[d]; k++) begin
                w = mem[exp_addr(d, k) & 16'h00FF];
                newb[d][k*16 +: 16] = w;
                s = s + w;
            end
            ok[d]   = (CS == 0) || (s == mem[CSUM_A[7:0]]);
            lend[d] = 1 + NW[d] + CS + LAT[d];
        end
        if (how == 0) reload = 1'b1;
        else begin flash_done = 1'b1; cfg_flag = 1'b1; end
        for (int i = 1; i <= lend[0] + 1; i++) begin
            step();
            reload = (i == poke);
            if (drop && i == 2) cfg_flag = 1'b0;
            chk($sformatf("en@%0d", i), 64'(bus_m.o_rd_ram_en), 64'(i <= NW[0] + CS));
            chk($sformatf("addr@%0d", i), 64'(bus_m.o_emib_addr),
                (i <= NW[0] + CS) ? 64'(exp_addr(0, i - 1)) : 64'd0);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("commit%0d@%0d", d, i), 64'(commit[d]), 64'(i == lend[d] && ok[d]));
                chk($sformatf("busy%0d@%0d", d, i), 64'(busy[d]), 64'(i <= lend[d]));
                chk($sformatf("cfg%0d@%0d", d, i), obs_cfg(d),
                    (i > lend[d] && ok[d]) ? newb[d] : exp_bank[d]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (ok[d]) begin
                exp_bank[d] = newb[d];
                exp_cnt[d]  = exp_cnt[d] + 8'd1;
                exp_done[d] = 1'b1;
                exp_err[d]  = 1'b0;
            end else begin
                exp_err[d]  = 1'b1;
            end
        end
        check_idle("post_load");
    endtask

    initial begin
        rst = 1'b1; flash_done = 1'b0; cfg_flag = 1'b0; reload = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        model_reset();
        step(); step();
        check_idle("in_reset");
        rst = 1'b0;
        step(); step();
        check_idle("after_reset");

        // Directed first load: RAM returns addr + 0x1000, started by flash_done rising.
        for (int a = 0; a < 256; a++) mem[a] = 16'(a) + 16'h1000;
        if (CS != 0) fix_csum();
        repeat (6) step();
        load(1, 0, 0);

        // Reload pulsed mid-issue is dropped; a later reload runs normally.
        randomize_mem();
        load(0, 2, 0);
        randomize_mem();
        load(0, 0, 0);

        // Dropping config_flag mid-load does not abort it; raising it again restarts.
        randomize_mem();
        load(0, 0, 1);
        randomize_mem();
        load(1, 0, 0);

        // Random contents, random idle gaps, random early reload pokes.
        for (int r = 0; r < 6; r++) begin
            randomize_mem();
            if (CS != 0 && $urandom_range(0, 1) == 1) fix_csum();
            repeat ($urandom_range(0, 3)) step();
            load(0, int'($urandom_range(0, 2)), 0);
        end

`ifdef EMIB_CFG_CHECKSUM_EN
        mem[8'h2C] = 16'h0001; mem[8'h2D] = 16'h0002; mem[8'h2E] = 16'h0003; mem[8'h26] = 16'h0004;
        mem[CSUM_A[7:0]] = 16'h000B;
        load(0, 0, 0);
        mem[CSUM_A[7:0]] = 16'h000A;
        load(0, 0, 0);
`endif

        // Reset while the second read is on the bus, then a clean load.
        randomize_mem();
        reload = 1'b1;
        step();
        reload = 1'b0;
        step();
        chk("mid_en", 64'(bus_m.o_rd_ram_en), 64'd1);
        chk("mid_addr", 64'(bus_m.o_emib_addr), 64'(tab[1]));
        rst = 1'b1;
        #1;
        model_reset();
        check_idle("async_rst");
        flash_done = 1'b0;
        step();
        rst = 1'b0;
        step(); step();
        check_idle("rst_release");
        randomize_mem();
        if (CS != 0) fix_csum();
        load(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
